catch_game_ctrl: RTL
====================

Name: catch_game_ctrl

Overview:
Frame-rate game sequencer for the XVGA (1024x768, 65 MHz) catch game. Owns paddle position, puck position and direction, score, lives and game phase. Advances once per frame on the vsync falling edge. Feeds the pixel renderer, which draws from paddle_y, puck_x and puck_y during the active frame.

Parameters:
SCREEN_W, 1024, active width in pixels
SCREEN_H, 768, active height in lines
PADDLE_W, 16, paddle width; paddle fixed at x=0
PADDLE_H, 128, paddle height
PUCK_SZ, 64, puck square side
PADDLE_STEP, 4, paddle pixels per frame
LIVES_INIT, 3, lives at game start (1..3)
SERVE_FRAMES, 60, frames puck is held before each serve

Ports:
vclock  in  1  65 MHz pixel clock
reset  in  1  synchronous, active-high
vsync  in  1  XVGA vertical sync, active low
start  in  1  level; begins game from IDLE or GAME_OVER
up  in  1  move paddle up
down  in  1  move paddle down
pspeed  in  4  puck speed in pixels/frame, latched at serve
frame_tick  out  1  one-cycle pulse per frame
paddle_y  out  10  paddle top line
puck_x  out  11  puck left column
puck_y  out  10  puck top line
score  out  8  catches, saturating at 255
lives  out  2  remaining lives
state  out  3  IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3
catch_pulse  out  1  one cycle on a catch
miss_pulse  out  1  one cycle on a miss

Behaviour:
- Reset (sync, on vclock): state=IDLE, paddle_y=320, puck_x=480, puck_y=352, dx=right, dy=down, score=0, lives=LIVES_INIT, serve counter=0, frame_tick=0, catch_pulse=0, miss_pulse=0. Reset mid-game has the same effect in one cycle and overrides every other event.
- frame_tick: vsync registered into vs_d. frame_tick is registered high for the one cycle after the first cycle with vs_d=1 and vsync=0. All game updates occur on the edge that ends the frame_tick cycle. Outputs change 1 cycle after frame_tick.
- IDLE: nothing moves. If start=1 on any cycle, go to SERVE with serve counter=0.
- Paddle, updated in SERVE and PLAY only:
  - up & !down: paddle_y -= PADDLE_STEP, saturating at 0.
  - down & !up: paddle_y += PADDLE_STEP, saturating at SCREEN_H-PADDLE_H (640).
  - Both or neither asserted: hold.
- SERVE:
  - Puck held at (480,352) with dx=right, dy=down.
  - Counter increments per frame_tick.
  - On the tick where counter reaches SERVE_FRAMES-1: latch spd = (pspeed==0) ? 1 : pspeed, go to PLAY.
- PLAY, per frame_tick. Compute x and y independently with 12-bit signed intermediates.
  - Right wall: if moving right and puck_x+spd >= SCREEN_W-PUCK_SZ, set puck_x=960 and dx=left.
  - Top wall: if moving up and puck_y < spd, set puck_y=0 and dy=down.
  - Bottom wall: if moving down and puck_y+spd >= SCREEN_H-PUCK_SZ, set puck_y=704 and dy=up.
  - Paddle plane: if moving left and puck_x <= PADDLE_W+spd, test overlap using the current (pre-update) paddle_y and puck_y: puck_y+PUCK_SZ > paddle_y && puck_y < paddle_y+PADDLE_H.
    - Catch (overlap true): puck_x=PADDLE_W, dx=right, score+1 saturating, catch_pulse=1. y motion still applies.
    - Miss (overlap false): miss_pulse=1, lives-1. If lives was 1, go to GAME_OVER with lives=0 and puck frozen. Otherwise go to SERVE with counter=0.
  - Otherwise: add or subtract spd on each axis.
  - A corner hit (right wall plus top or bottom in the same frame) reflects both axes.
- GAME_OVER: everything frozen, score held. start=1 sets score=0, lives=LIVES_INIT, paddle_y=320, and goes to SERVE.
- A pspeed change during PLAY has no effect until the next serve.
- catch_pulse and miss_pulse are mutually exclusive and never coincide with frame_tick.

Decomposition:
- Package catch_pkg holds:
  - state encoding constants;
  - serve position (480,352) and paddle home (320);
  - screen bounds derived from SCREEN_W and SCREEN_H.
- One sub-module, catch_frame_tick: vsync edge detector producing the registered frame_tick.
- Collision and reflection logic stays inline.

Test Plan:
- Reset then no start, 5 frames → state=0, paddle_y=320, puck=(480,352), lives=3, no pulses.
- start=1, pspeed=0, 60 frames → state=2 and spd latched 1. Next frame: puck=(481,353).
- PLAY with up held for 100 frames → paddle_y decrements 4/frame, saturates at 0. Same check with down held → saturates at 640. up and down held together → no change.
- pspeed=8, puck at x=952 moving right → puck_x=960, dx=left. Puck at y=700 moving down → puck_y=704, dy=up.
- Puck moving left at x=20, spd=8, puck_y=300, paddle_y=320 (overlap) → catch_pulse for one cycle, score 0→1, puck_x=16, dx=right.
- Same approach with paddle_y=0, three times → miss_pulse each time, lives 3→2→1→0, final state=3. Then start=1 → score=0, lives=3, state=1. reset asserted mid-PLAY → IDLE values one cycle later.

Source files
------------

// File: rtl/catch_pkg.sv
// catch_pkg: shared constants, state encoding and coordinate type for the
// catch game sequencer and its helpers.
package catch_pkg;

  localparam int SCREEN_W     = 1024;
  localparam int SCREEN_H     = 768;
  localparam int PADDLE_W     = 16;
  localparam int PADDLE_H     = 128;
  localparam int PUCK_SZ      = 64;
  localparam int PADDLE_STEP  = 4;
  localparam int LIVES_INIT   = 3;
  localparam int SERVE_FRAMES = 60;

  // Signed working type for position arithmetic; wide enough that
  // position +/- speed never wraps.
  typedef logic signed [11:0] coord_t;

  // Screen bounds for the puck's top-left corner and the paddle's top line.
  localparam coord_t X_MAX     = coord_t'(SCREEN_W - PUCK_SZ);   // 960
  localparam coord_t Y_MAX     = coord_t'(SCREEN_H - PUCK_SZ);   // 704
  localparam coord_t PAD_Y_MAX = coord_t'(SCREEN_H - PADDLE_H);  // 640
  localparam coord_t PAD_X     = coord_t'(PADDLE_W);
  localparam coord_t PAD_H     = coord_t'(PADDLE_H);
  localparam coord_t PUCK_S    = coord_t'(PUCK_SZ);
  localparam coord_t PAD_STEP  = coord_t'(PADDLE_STEP);

  // Serve position and paddle home.
  localparam logic [10:0] SERVE_X     = 11'd480;
  localparam logic [9:0]  SERVE_Y     = 10'd352;
  localparam logic [9:0]  PADDLE_HOME = 10'd320;

  localparam logic [1:0] LIVES_START = 2'(LIVES_INIT);
  localparam logic [5:0] SERVE_LAST  = 6'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GAME_OVER = 3'd3
  } state_e;

endpackage

// File: rtl/catch_frame_tick.sv
// catch_frame_tick: detects the vsync falling edge and emits a registered
// one-cycle frame_tick in the cycle after the edge is seen.
module catch_frame_tick (
  input  logic vclock_i,
  input  logic reset_i,
  input  logic vsync_i,
  output logic frame_tick_o
);

  logic vs_q;
  logic tick_q;

  // Register vsync and flag the first cycle where it has dropped.
  // NOTE: reset is synchronous (sampled only on the clock edge), and all
  // sequential state uses non-blocking assignments so every flop samples
  // pre-edge values.
  always_ff @(posedge vclock_i) begin
    if (reset_i) begin
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= vsync_i;
      tick_q <= vs_q & ~vsync_i;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/catch_game_ctrl.sv
// catch_game_ctrl: per-frame game sequencer owning paddle, puck, score,
// lives and game phase. All game updates happen on the edge that ends
// the frame_tick cycle.
module catch_game_ctrl
  import catch_pkg::*;
(
  input  logic        vclock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        start,
  input  logic        up,
  input  logic        down,
  input  logic [3:0]  pspeed,
  output logic        frame_tick,
  output logic [9:0]  paddle_y,
  output logic [10:0] puck_x,
  output logic [9:0]  puck_y,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [2:0]  state,
  output logic        catch_pulse,
  output logic        miss_pulse
);

  state_e      state_q, state_d;
  logic [9:0]  paddle_q, paddle_d;
  logic [10:0] puck_x_q, puck_x_d;
  logic [9:0]  puck_y_q, puck_y_d;
  logic        dx_left_q, dx_left_d;
  logic        dy_up_q, dy_up_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [5:0]  serve_cnt_q, serve_cnt_d;
  logic [3:0]  spd_q, spd_d;
  logic        catch_q, catch_d;
  logic        miss_q, miss_d;
  logic        tick;

  coord_t x_s, y_s, pad_s, spd_s, x_next, y_next;
  logic   dx_left_nx, dy_up_nx, overlap, catch_hit, miss_hit;

  catch_frame_tick u_frame_tick (
    .vclock_i     (vclock),
    .reset_i      (reset),
    .vsync_i      (vsync),
    .frame_tick_o (tick)
  );

  assign x_s   = $signed({1'b0, puck_x_q});
  assign y_s   = $signed({2'b00, puck_y_q});
  assign pad_s = $signed({2'b00, paddle_q});
  assign spd_s = $signed({8'h00, spd_q});

  // Puck rows [y, y+64) intersect paddle rows [pad, pad+128).
  assign overlap = (y_s + PUCK_S > pad_s) && (y_s < pad_s + PAD_H);

  // Horizontal motion: right-wall reflection, or paddle-plane catch/miss.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    x_next     = x_s;
    dx_left_nx = dx_left_q;
    catch_hit  = 1'b0;
    miss_hit   = 1'b0;
    if (!dx_left_q) begin
      if (x_s + spd_s >= X_MAX) begin
        x_next     = X_MAX;
        dx_left_nx = 1'b1;
      end else begin
        x_next = x_s + spd_s;
      end
    end else if (x_s <= PAD_X + spd_s) begin
      if (overlap) begin
        x_next     = PAD_X;
        dx_left_nx = 1'b0;
        catch_hit  = 1'b1;
      end else begin
        miss_hit = 1'b1;
      end
    end else begin
      x_next = x_s - spd_s;
    end
  end

  // Vertical motion: top and bottom wall reflection.
  always_comb begin
    y_next   = y_s;
    dy_up_nx = dy_up_q;
    if (dy_up_q) begin
      if (y_s < spd_s) begin
        y_next   = '0;
        dy_up_nx = 1'b0;
      end else begin
        y_next = y_s - spd_s;
      end
    end else if (y_s + spd_s >= Y_MAX) begin
      y_next   = Y_MAX;
      dy_up_nx = 1'b1;
    end else begin
      y_next = y_s + spd_s;
    end
  end

  // Game phase register.
  always_ff @(posedge vclock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Game phase transitions: start is a level seen on any cycle, the rest
  // only on frame ticks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: if (start) state_d = ST_SERVE;
      ST_SERVE: if (tick && serve_cnt_q == SERVE_LAST) state_d = ST_PLAY;
      ST_PLAY:  if (tick && miss_hit)
                  state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_SERVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for paddle, puck, score, lives, serve counter and pulses.
  always_comb begin
    paddle_d    = paddle_q;
    puck_x_d    = puck_x_q;
    puck_y_d    = puck_y_q;
    dx_left_d   = dx_left_q;
    dy_up_d     = dy_up_q;
    score_d     = score_q;
    lives_d     = lives_q;
    serve_cnt_d = serve_cnt_q;
    spd_d       = spd_q;
    catch_d     = 1'b0;
    miss_d      = 1'b0;

    if (tick && (state_q == ST_SERVE || state_q == ST_PLAY)) begin
      if (up && !down)
        paddle_d = (pad_s < PAD_STEP) ? '0 : 10'(pad_s - PAD_STEP);
      else if (down && !up)
        paddle_d = (pad_s + PAD_STEP > PAD_Y_MAX) ? 10'(PAD_Y_MAX)
                                                  : 10'(pad_s + PAD_STEP);
    end

    if (state_q == ST_GAME_OVER && start) begin
      score_d  = '0;
      lives_d  = LIVES_START;
      paddle_d = PADDLE_HOME;
    end else if (tick && state_q == ST_SERVE) begin
      if (serve_cnt_q == SERVE_LAST) spd_d = (pspeed == 4'd0) ? 4'd1 : pspeed;
      else                           serve_cnt_d = serve_cnt_q + 6'd1;
    end else if (tick && state_q == ST_PLAY) begin
      if (miss_hit) begin
        miss_d  = 1'b1;
        lives_d = lives_q - 2'd1;
      end else begin
        puck_x_d  = 11'(x_next);
        puck_y_d  = 10'(y_next);
        dx_left_d = dx_left_nx;
        dy_up_d   = dy_up_nx;
        if (catch_hit) begin
          catch_d = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        end
      end
    end

    // Every entry into SERVE re-centres the puck and restarts the hold count.
    if (state_d == ST_SERVE && state_q != ST_SERVE) begin
      puck_x_d    = SERVE_X;
      puck_y_d    = SERVE_Y;
      dx_left_d   = 1'b0;
      dy_up_d     = 1'b0;
      serve_cnt_d = '0;
    end
  end

  // Game datapath registers.
  always_ff @(posedge vclock) begin
    if (reset) begin
      paddle_q    <= PADDLE_HOME;
      puck_x_q    <= SERVE_X;
      puck_y_q    <= SERVE_Y;
      dx_left_q   <= 1'b0;
      dy_up_q     <= 1'b0;
      score_q     <= '0;
      lives_q     <= LIVES_START;
      serve_cnt_q <= '0;
      spd_q       <= 4'd1;
      catch_q     <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      paddle_q    <= paddle_d;
      puck_x_q    <= puck_x_d;
      puck_y_q    <= puck_y_d;
      dx_left_q   <= dx_left_d;
      dy_up_q     <= dy_up_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      serve_cnt_q <= serve_cnt_d;
      spd_q       <= spd_d;
      catch_q     <= catch_d;
      miss_q      <= miss_d;
    end
  end

  assign frame_tick  = tick;
  assign paddle_y    = paddle_q;
  assign puck_x      = puck_x_q;
  assign puck_y      = puck_y_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign state       = state_q;
  assign catch_pulse = catch_q;
  assign miss_pulse  = miss_q;

endmodule
